// File: rtl/uart_tx_fifo.sv
// AXI-Stream to UART transmitter with a beat FIFO; each W_OUT-bit beat is sent
// as NUM_WORDS back-to-back frames, word 0 first, LSB first within a word.
module uart_tx_fifo #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_OUT            = 16,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [W_OUT-1:0]                 s_data,
    output logic                             tx,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

    localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
    localparam int STOP_CLKS = STOP_BITS * CLOCKS_PER_PULSE;
    localparam int CLK_W     = $clog2(STOP_CLKS);
    localparam int BIT_W     = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int WORD_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                   state;
    logic [W_OUT-1:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [W_OUT-1:0]         beat_rest;
    logic [BITS_PER_WORD-1:0] word_sr;
    logic                     par_bit;
    logic [CLK_W-1:0]         clk_cnt;
    logic [BIT_W-1:0]         bit_cnt;
    logic [WORD_W-1:0]        word_idx;

    logic                     push;
    logic                     pop;
    logic                     pulse_end;
    logic                     stop_end;
    logic                     last_word;
    logic [BITS_PER_WORD-1:0] next_word;
    logic [BITS_PER_WORD-1:0] word_shift;
    logic [W_OUT-1:0]         next_rest;
    logic                     next_par;

    // s_ready comes straight from the count register: no bypass when full.
    assign s_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign busy    = (state != IDLE);
    assign push    = s_valid && s_ready;

    always_comb begin
        // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
        pulse_end  = (clk_cnt == CLK_W'(CLOCKS_PER_PULSE - 1));
        stop_end   = (clk_cnt == CLK_W'(STOP_CLKS - 1));
        last_word  = (word_idx == WORD_W'(NUM_WORDS - 1));
        pop        = (fifo_count != '0) &&
                     ((state == IDLE) || ((state == STOP) && stop_end && last_word));
        next_word  = pop ? mem[rd_ptr][BITS_PER_WORD-1:0] : beat_rest[BITS_PER_WORD-1:0];
        next_rest  = pop ? (mem[rd_ptr] >> BITS_PER_WORD) : (beat_rest >> BITS_PER_WORD);
        next_par   = (^next_word) ^ (PARITY == 2);
        word_shift = word_sr >> 1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                fifo_count <= fifo_count + CNT_W'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - CNT_W'(1);
        end
    end

    // NOTE: the storage array has no reset; the pointers flush it, and it can map to plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            word_idx  <= '0;
            word_sr   <= '0;
            beat_rest <= '0;
            par_bit   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state     <= START;
                        tx        <= 1'b0;
                        clk_cnt   <= '0;
                        word_idx  <= '0;
                        word_sr   <= next_word;
                        beat_rest <= next_rest;
                        par_bit   <= next_par;
                    end
                end
                START: begin
                    if (pulse_end) begin
                        state   <= DATA;
                        tx      <= word_sr[0];
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end
                DATA: begin
                    if (pulse_end) begin
                        clk_cnt <= '0;
                        if (bit_cnt == BIT_W'(BITS_PER_WORD - 1)) begin
                            if (PARITY != 0) begin
                                state <= PAR;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            word_sr <= word_shift;
                            tx      <= word_shift[0];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end
                PAR: begin
                    if (pulse_end) begin
                        state   <= STOP;
                        tx      <= 1'b1;
                        clk_cnt <= '0;
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end
                STOP: begin
                    if (stop_end) begin
                        clk_cnt <= '0;
                        // Next word of this beat or head of the FIFO starts with no idle gap.
                        if (!last_word || pop) begin
                            state     <= START;
                            tx        <= 1'b0;
                            word_idx  <= last_word ? '0 : word_idx + WORD_W'(1);
                            word_sr   <= next_word;
                            beat_rest <= next_rest;
                            par_bit   <= next_par;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CLK_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
